// File: rtl/div_seq.sv
// div_seq: sequential signed restoring divider for the DIV instruction.
// Produces quotient on lo and remainder on hi (MIPS semantics: truncation
// toward zero, remainder carries the dividend's sign). One restoring step
// per cycle; magnitudes are processed unsigned, signs fixed up at the end.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  // The settled partial remainder is always below the divisor, so WIDTH bits
  // hold it; the shifted value and the trial difference need WIDTH+1 bits.
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    count_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;
  logic             div_zero_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // Operand magnitudes (modulo 2^WIDTH, so the most negative value maps to
  // unsigned 2^(WIDTH-1)) and the trial subtraction for the current step.
  always_comb begin
    abs_a     = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    abs_b     = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_reg};
  end

  // Control FSM and datapath; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      count_reg    <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg     <= 1'b0;
          div_zero_reg <= 1'b0;
          if (start) begin
            if (b == '0) begin
              // Divide by zero: report immediately, leave hi/lo untouched.
              done_reg     <= 1'b1;
              div_zero_reg <= 1'b1;
              state_reg    <= DONE;
            end else begin
              sign_q_reg <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r_reg <= a[WIDTH-1];
              quo_reg    <= abs_a;
              dvs_reg    <= abs_b;
              rem_reg    <= '0;
              count_reg  <= CW'(WIDTH);
              busy_reg   <= 1'b1;
              state_reg  <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            rem_reg <= trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= rem_shift[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          lo_reg    <= sign_q_reg ? (WIDTH'(0) - quo_reg) : quo_reg;
          hi_reg    <= sign_r_reg ? (WIDTH'(0) - rem_reg) : rem_reg;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg     <= 1'b0;
          div_zero_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized self-checking bench for div_seq against a plain
// signed-arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_zero;
  logic        busy;

  int checks;
  int errors;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .done     (done),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV via 64-bit signed arithmetic (truncating division,
  // remainder sign follows dividend), results taken modulo 2^32.
  function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // One divide; inject_at > 0 drives a second start with junk operands so
  // that it is sampled at edge E<inject_at>.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input int inject_at);
    int  edge_n;
    int  busy_cnt;
    bit  is_zero;
    logic [31:0] q;
    logic [31:0] r;
    is_zero = (bv == 32'd0);
    if (!is_zero) begin
      ref_div(av, bv, q, r);
      exp_lo = q;
      exp_hi = r;
    end
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    edge_n = 0;
    busy_cnt = 0;
    while (!done && edge_n < 100) begin
      if (busy) busy_cnt++;
      start = (inject_at > 0 && edge_n == inject_at - 1);
      if (start) begin
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk);
      #1;
      edge_n++;
    end
    start = 1'b0;
    $display("div a=0x%08h b=0x%08h -> lo=0x%08h hi=0x%08h dz=%0b edge=%0d",
             av, bv, lo, hi, div_zero, edge_n);
    check("done_edge", 32'(edge_n), is_zero ? 32'd0 : 32'd33);
    check("busy_cycles", 32'(busy_cnt), is_zero ? 32'd0 : 32'd33);
    check("div_zero", {31'd0, div_zero}, {31'd0, is_zero});
    check("lo", lo, exp_lo);
    check("hi", hi, exp_hi);
    @(posedge clk);
    #1;
    check("done_drop", {31'd0, done}, 32'd0);
    check("lo_hold", lo, exp_lo);
    check("hi_hold", hi, exp_hi);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0;
    errors = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Directed cases.
    run_div(32'd100, 32'd7, 0);
    run_div(32'd5, 32'd0, 0);            // hi/lo keep 2/14
    check("dz_keep_lo", lo, 32'd14);
    check("dz_keep_hi", hi, 32'd2);
    run_div(32'hFFFFFFF9, 32'd2, 0);
    run_div(32'd7, 32'hFFFFFFFE, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 0);
    run_div(32'h80000000, 32'h80000000, 0);
    run_div(32'd3, 32'h80000000, 0);
    run_div(32'd1000, 32'd3, 5);          // second start at E5 ignored

    // Reset at E10 of a running divide.
    @(negedge clk);
    a = 32'd12345;
    b = 32'd67;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Reset and start on the same edge: request dropped.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a = 32'd50;
    b = 32'd5;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(posedge clk);
      #1;
    end
    check("rst_start_drop", 32'(dones), 32'd0);
    check("rst_start_lo", lo, 32'd0);

    // Randomized divides, mixing magnitudes and signs.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_div(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
